muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit that owns the HI/LO register pair for the MIPS datapath. It replaces single-cycle HI/LO arithmetic with a one-bit-per-cycle engine supporting signed and unsigned MULT/DIV, MTHI/MTLO, and a pipeline flush. The controller stalls on `busy`. MFHI/MFLO read `hi`/`lo` directly.

---
 rtl/global_types.sv | 15 +
 rtl/muldiv_unit.sv | 110 +++++++++++
 tb/tb_muldiv_unit.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/global_types.sv
// global_types: shared enums and op-decode/negate helpers for the HI/LO multiply/divide path
package global_types;
  typedef enum logic [2:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO} muldiv_op_t;
  typedef enum logic [1:0] {IDLE, CALC, FIX} muldiv_state_t;
  localparam int MD_MAX_W = 64;
  function automatic logic is_signed_op(input muldiv_op_t op);
    return op == MD_MULT || op == MD_DIV;
  endfunction
  function automatic logic is_div_op(input muldiv_op_t op);
    return op == MD_DIV || op == MD_DIVU;
  endfunction
  function automatic logic [2*MD_MAX_W-1:0] cond_neg(input logic [2*MD_MAX_W-1:0] v, input logic n);
    return n ? -v : v;
  endfunction
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: one-bit-per-cycle signed/unsigned multiply/divide engine owning HI/LO
module muldiv_unit
  import global_types::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int FW = 2 * MD_MAX_W;
  muldiv_op_t      op_e;
  muldiv_state_t   state;
  logic [CW-1:0]   cnt;
  logic            is_div, sgn_q, sgn_r, b_zero, sgn_in;
  logic [WIDTH-1:0] divisor, orig_a;
  logic [2*WIDTH-1:0] acc, mult_next;
  logic [WIDTH:0]  rem, rem_next, sum, shl;
  logic [WIDTH+1:0] diff;
  logic [WIDTH-1:0] quo_next;
  logic [FW-1:0]   na, nb, np, nq, nr;
  logic            unused_ok;
  assign op_e   = muldiv_op_t'(op);
  assign sgn_in = is_signed_op(op_e);
  assign na = cond_neg(FW'(a), sgn_in & a[WIDTH-1]);
  assign nb = cond_neg(FW'(b), sgn_in & b[WIDTH-1]);
  assign np = cond_neg(FW'(acc), sgn_q);
  assign nq = cond_neg(FW'(acc[WIDTH-1:0]), sgn_q);
  assign nr = cond_neg(FW'(rem[WIDTH-1:0]), sgn_r);
  assign unused_ok = ^{na, nb, np, nq, nr, rem[WIDTH]};
  // Multiply: low half of acc holds the multiplier, shifted out as the product shifts in
  assign sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, divisor} : '0);
  assign mult_next = {sum, acc[WIDTH-1:1]};
  // Restoring divide: low half of acc holds the dividend, replaced by quotient bits
  assign shl      = {rem[WIDTH-1:0], acc[WIDTH-1]};
  assign diff     = {1'b0, shl} - {2'b0, divisor};
  assign rem_next = diff[WIDTH+1] ? shl : diff[WIDTH:0];
  assign quo_next = {acc[WIDTH-2:0], ~diff[WIDTH+1]};
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      acc         <= '0;
      rem         <= '0;
      divisor     <= '0;
      orig_a      <= '0;
      is_div      <= 1'b0;
      sgn_q       <= 1'b0;
      sgn_r       <= 1'b0;
      b_zero      <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      if (abort && state != IDLE) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start && !abort) begin
            if (op_e == MD_MTHI) hi <= a;
            else if (op_e == MD_MTLO) lo <= a;
            else if (op_e inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU}) begin
              is_div  <= is_div_op(op_e);
              sgn_q   <= sgn_in & (a[WIDTH-1] ^ b[WIDTH-1]);
              sgn_r   <= sgn_in & a[WIDTH-1];
              b_zero  <= b == '0;
              orig_a  <= a;
              divisor <= nb[WIDTH-1:0];
              acc     <= {{WIDTH{1'b0}}, na[WIDTH-1:0]};
              rem     <= '0;
              cnt     <= '0;
              busy    <= 1'b1;
              state   <= CALC;
            end
          end
          CALC: begin
            acc   <= is_div ? {acc[2*WIDTH-1:WIDTH], quo_next} : mult_next;
            rem   <= is_div ? rem_next : rem;
            cnt   <= cnt + 1'b1;
            state <= (cnt == CW'(WIDTH - 1)) ? FIX : CALC;
          end
          FIX: begin
            hi          <= !is_div ? np[2*WIDTH-1:WIDTH] : b_zero ? orig_a : nr[WIDTH-1:0];
            lo          <= !is_div ? np[WIDTH-1:0] : b_zero ? '1 : nq[WIDTH-1:0];
            done        <= 1'b1;
            div_by_zero <= is_div & b_zero;
            busy        <= 1'b0;
            state       <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for the HI/LO multiply/divide unit
module tb_muldiv_unit;
  import global_types::*;
  logic        clock, reset, start, abort;
  logic [2:0]  op;
  logic [31:0] a, b, hi, lo;
  logic        busy, done, div_by_zero;
  int passed = 0, total = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b), .abort(abort),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  // Called at a negedge; start is sampled at the following posedge (E0)
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1; op = o; a = x; b = y;
    @(negedge clock);
    start = 0;
  endtask

  // Counts negedges after E0 until done is seen, bounded
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      n++;
      if (done) break;
    end
  endtask

  task automatic test_reset;
    reset = 1; start = 0; abort = 0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clock);
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0 || div_by_zero !== 1'b0) $display("FAIL reset_pulses got %b%b want 00", done, div_by_zero); else passed++;
    total++; if ({hi, lo} !== 64'h0) $display("FAIL reset_hilo got %h_%h want 0", hi, lo); else passed++;
    reset = 0;
    @(negedge clock);
  endtask

  task automatic test_multu;
    int n;
    issue(MD_MULTU, 32'h7FFF, 32'h7FFF);
    total++; if (busy !== 1'b1) $display("FAIL multu_busy got %b want 1", busy); else passed++;
    wait_done(n);
    total++; if (n !== 33) $display("FAIL multu_latency got %0d want 33", n); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL multu_busy_done got %b want 0", busy); else passed++;
    total++; if ({hi, lo} !== 64'h0000_0000_3FFF_0001) $display("FAIL multu1 got %h_%h want 00000000_3fff0001", hi, lo); else passed++;
    issue(MD_MULTU, 32'h3FFF_0001, 32'h7FFF);
    wait_done(n);
    total++; if (n !== 33) $display("FAIL multu2_latency got %0d want 33", n); else passed++;
    total++; if ({hi, lo} !== 64'h0000_1FFF_4001_7FFF) $display("FAIL multu2 got %h_%h want 00001fff_40017fff", hi, lo); else passed++;
    total++; if (div_by_zero !== 1'b0) $display("FAIL multu_dz got %b want 0", div_by_zero); else passed++;
  endtask

  task automatic test_back_to_back;
    int n;
    issue(MD_DIVU, 32'd257, 32'd16);
    wait_done(n);
    total++; if ({hi, lo} !== {32'd1, 32'd16}) $display("FAIL divu got %h_%h want 00000001_00000010", hi, lo); else passed++;
    issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
    wait_done(n);
    total++; if (n !== 33) $display("FAIL b2b_latency got %0d want 33", n); else passed++;
    total++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFA) $display("FAIL mult_neg got %h_%h want ffffffff_fffffffa", hi, lo); else passed++;
  endtask

  task automatic test_signed;
    int n;
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(n);
    total++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) $display("FAIL div_neg got %h_%h want ffffffff_fffffffd", hi, lo); else passed++;
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n);
    total++; if (n !== 33) $display("FAIL div_ovf_latency got %0d want 33", n); else passed++;
    total++; if ({hi, lo} !== 64'h0000_0000_8000_0000) $display("FAIL div_ovf got %h_%h want 00000000_80000000", hi, lo); else passed++;
    issue(MD_DIV, 32'd7, 32'hFFFF_FFFE);
    wait_done(n);
    total++; if ({hi, lo} !== 64'h0000_0001_FFFF_FFFD) $display("FAIL div_negb got %h_%h want 00000001_fffffffd", hi, lo); else passed++;
  endtask

  task automatic test_div_zero;
    int n;
    issue(MD_DIVU, 32'h1234, 32'h0);
    wait_done(n);
    total++; if (n !== 33) $display("FAIL dz_latency got %0d want 33", n); else passed++;
    total++; if (div_by_zero !== 1'b1) $display("FAIL dz_pulse got %b want 1", div_by_zero); else passed++;
    total++; if ({hi, lo} !== 64'h0000_1234_FFFF_FFFF) $display("FAIL divu_zero got %h_%h want 00001234_ffffffff", hi, lo); else passed++;
    @(negedge clock);
    total++; if ({done, div_by_zero} !== 2'b00) $display("FAIL dz_one_cycle got %b%b want 00", done, div_by_zero); else passed++;
    issue(MD_DIV, 32'hFFFF_FFFB, 32'h0);
    wait_done(n);
    total++; if ({div_by_zero, hi, lo} !== {1'b1, 64'hFFFF_FFFB_FFFF_FFFF}) $display("FAIL div_zero_signed got %b %h_%h want 1 fffffffb_ffffffff", div_by_zero, hi, lo); else passed++;
  endtask

  task automatic test_mthi_mtlo;
    issue(MD_MTHI, 32'hAAAA_0000, 32'h0);
    total++; if (hi !== 32'hAAAA_0000) $display("FAIL mthi got %h want aaaa0000", hi); else passed++;
    total++; if ({busy, done} !== 2'b00) $display("FAIL mthi_busy got %b%b want 00", busy, done); else passed++;
    issue(MD_MTLO, 32'h0BAD_F00D, 32'h0);
    total++; if ({hi, lo} !== 64'hAAAA_0000_0BAD_F00D) $display("FAIL mtlo got %h_%h want aaaa0000_0badf00d", hi, lo); else passed++;
  endtask

  task automatic test_start_while_busy;
    int n;
    issue(MD_MULTU, 32'h7FFF, 32'h7FFF);
    repeat (4) @(negedge clock);
    issue(MD_DIVU, 32'd100, 32'd0);
    wait_done(n);
    total++; if (n !== 28) $display("FAIL swb_latency got %0d want 28", n); else passed++;
    total++; if ({div_by_zero, hi, lo} !== {1'b0, 64'h0000_0000_3FFF_0001}) $display("FAIL swb_result got %b %h_%h want 0 00000000_3fff0001", div_by_zero, hi, lo); else passed++;
    @(negedge clock);
    total++; if (busy !== 1'b0) $display("FAIL swb_idle got %b want 0", busy); else passed++;
  endtask

  task automatic test_abort;
    bit seen;
    issue(MD_MTLO, 32'h55, 32'h0);
    issue(MD_MTHI, 32'h66, 32'h0);
    issue(MD_MULTU, 32'd3, 32'd4);
    repeat (9) @(negedge clock);
    abort = 1;
    @(negedge clock);
    abort = 0;
    total++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else passed++;
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) seen = 1;
    end
    total++; if (seen !== 1'b0) $display("FAIL abort_done got %b want 0", seen); else passed++;
    total++; if ({hi, lo} !== 64'h0000_0066_0000_0055) $display("FAIL abort_hilo got %h_%h want 00000066_00000055", hi, lo); else passed++;
    abort = 1;
    issue(MD_MTHI, 32'h1, 32'h0);
    issue(MD_MULTU, 32'd2, 32'd2);
    abort = 0;
    total++; if ({busy, hi} !== {1'b0, 32'h66}) $display("FAIL abort_start got %b %h want 0 00000066", busy, hi); else passed++;
  endtask

  task automatic test_reset_mid;
    int n;
    issue(MD_DIVU, 32'd1000, 32'd3);
    repeat (10) @(negedge clock);
    #2 reset = 1;
    #1;
    total++; if ({busy, hi, lo} !== 65'h0) $display("FAIL reset_mid got %b %h_%h want 0 00000000_00000000", busy, hi, lo); else passed++;
    @(negedge clock);
    reset = 0;
    @(negedge clock);
    issue(MD_DIVU, 32'd100, 32'd7);
    wait_done(n);
    total++; if (n !== 33) $display("FAIL post_reset_latency got %0d want 33", n); else passed++;
    total++; if ({hi, lo} !== {32'd2, 32'd14}) $display("FAIL post_reset_divu got %h_%h want 00000002_0000000e", hi, lo); else passed++;
  endtask

  initial begin
    test_reset;
    test_multu;
    test_back_to_back;
    test_signed;
    test_div_zero;
    test_mthi_mtlo;
    test_start_while_busy;
    test_abort;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
